// File: rtl/prog_ram.sv
// prog_ram: parametrised single-port program/data RAM with registered read and a byte-stream loader.
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   addr, din, we      run-mode read/write address, write data, write strobe
//   oe_n, bus_out      active-low output enable; registered read data, 0 when disabled
//   prog_mode          1 = loader owns the write port
//   ld_valid, ld_data  loader stream word, handshaken against ld_ready
//   ld_ready           loader accepts a word this cycle
//   ld_restart         pulse: loader pointer to 0, clear ld_wrap
//   ld_addr, ld_wrap   loader write pointer; sticky wrap flag
//   busy               power-on clear sweep in progress
// Build option: define RAM_CLEAR_EN to zero every word after reset (CLEAR state).
module prog_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    input  logic              we,
    input  logic              oe_n,
    output logic [DATA_W-1:0] bus_out,
    input  logic              prog_mode,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic              ld_restart,
    output logic [ADDR_W-1:0] ld_addr,
    output logic              ld_wrap,
    output logic              busy
);
    localparam int DEPTH = 2 ** ADDR_W;
`ifdef RAM_CLEAR_EN
    typedef enum logic [1:0] {RUN = 2'd0, LOAD = 2'd1, CLEAR = 2'd2} state_t;
    localparam state_t RESET_ST = CLEAR;
`else
    typedef enum logic [1:0] {RUN = 2'd0, LOAD = 2'd1} state_t;
    localparam state_t RESET_ST = RUN;
`endif
    state_t state_q, state_d;
    logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
    logic ld_wrap_q, ld_wrap_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic hs, mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;
`ifdef RAM_CLEAR_EN
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= RESET_ST;
        else state_q <= state_d;
    end

    // RUN and LOAD both simply follow prog_mode; CLEAR holds until its last word.
    always_comb begin
        state_d = prog_mode ? LOAD : RUN;
`ifdef RAM_CLEAR_EN
        if (state_q == CLEAR && clr_cnt_q != ADDR_W'(DEPTH - 1)) state_d = CLEAR;
`endif
    end

    always_comb begin
        ld_ready = state_q == LOAD;
        hs = ld_valid && ld_ready;
        mem_we = hs || (we && state_q == RUN);
        mem_wa = hs ? ld_addr_q : addr;
        mem_wd = hs ? ld_data : din;
`ifdef RAM_CLEAR_EN
        if (state_q == CLEAR) begin
            mem_we = 1'b1;
            mem_wa = clr_cnt_q;
            mem_wd = '0;
        end
        clr_cnt_d = clr_cnt_q + ADDR_W'(state_q == CLEAR);
`endif
        // Restart wins the pointer even when a word is accepted in the same cycle.
        ld_addr_d = ld_restart ? '0 : ld_addr_q + ADDR_W'(hs);
        ld_wrap_d = !ld_restart && (ld_wrap_q || (hs && &ld_addr_q));
        rd_d = mem[addr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_addr_q <= '0;
            ld_wrap_q <= 1'b0;
            rd_q <= '0;
        end else begin
            ld_addr_q <= ld_addr_d;
            ld_wrap_q <= ld_wrap_d;
            rd_q <= rd_d;
        end
    end

`ifdef RAM_CLEAR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) clr_cnt_q <= '0;
        else clr_cnt_q <= clr_cnt_d;
    end
    assign busy = state_q == CLEAR;
`else
    assign busy = 1'b0;
`endif

    // Array is not reset; the read register samples the pre-write contents (read-first).
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    assign bus_out = oe_n ? '0 : rd_q;
    assign ld_addr = ld_addr_q;
    assign ld_wrap = ld_wrap_q;
endmodule

// File: tb/tb_prog_ram.sv
// tb_prog_ram: randomized and directed checks of prog_ram against a behavioural memory model.
module tb_prog_ram;
    localparam int DEPTH = 16;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [3:0] addr = '0;
    logic [7:0] din = '0;
    logic we = 1'b0;
    logic oe_n = 1'b1;
    logic [7:0] bus_out;
    logic prog_mode = 1'b0;
    logic ld_valid = 1'b0;
    logic [7:0] ld_data = '0;
    logic ld_ready;
    logic ld_restart = 1'b0;
    logic [3:0] ld_addr;
    logic ld_wrap;
    logic busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: memory with known-flags, loader pointer, mode.
    logic [7:0] mm [DEPTH];
    bit known [DEPTH];
    logic [3:0] m_ptr;
    bit m_wrap, m_load, m_busy;
    int m_clr;
    logic [7:0] m_rd;
    bit m_rdk;

    prog_ram #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .addr(addr), .din(din), .we(we), .oe_n(oe_n),
        .bus_out(bus_out), .prog_mode(prog_mode), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .ld_restart(ld_restart), .ld_addr(ld_addr), .ld_wrap(ld_wrap),
        .busy(busy)
    );

    always #5 clk = ~clk;

`ifdef RAM_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    task automatic model_reset();
        m_ptr = '0;
        m_wrap = 0;
        m_load = 0;
        m_busy = CLR;
        m_clr = 0;
        m_rd = '0;
        m_rdk = 1;
    endtask

    // Advance one clock, applying the behaviour at that edge to the model first.
    task automatic cyc();
        bit hs;
        hs = ld_valid && m_load;
        m_rd = mm[addr];
        m_rdk = known[addr];
        if (m_busy) begin
            mm[m_clr] = 8'h00;
            known[m_clr] = 1;
        end else if (hs) begin
            mm[m_ptr] = ld_data;
            known[m_ptr] = 1;
        end else if (!m_load && we) begin
            mm[addr] = din;
            known[addr] = 1;
        end
        if (hs) begin
            if (m_ptr == 4'd15) m_wrap = 1;
            m_ptr = m_ptr + 4'd1;
        end
        if (ld_restart) begin
            m_ptr = '0;
            m_wrap = 0;
        end
        if (m_busy) begin
            if (m_clr == DEPTH - 1) begin
                m_busy = 0;
                m_load = prog_mode;
            end
            m_clr++;
        end else begin
            m_load = prog_mode;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < DEPTH; i++) known[i] = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        oe_n = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (bus_out !== 8'h00) begin n_bad++; $display("FAIL reset_bus_out got %h want 00", bus_out); end
        n_cmp++; if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ld_ready got %b want 0", ld_ready); end
        n_cmp++; if (ld_addr !== 4'h0) begin n_bad++; $display("FAIL reset_ld_addr got %h want 0", ld_addr); end
        n_cmp++; if (ld_wrap !== 1'b0) begin n_bad++; $display("FAIL reset_ld_wrap got %b want 0", ld_wrap); end
        n_cmp++; if (busy !== CLR) begin n_bad++; $display("FAIL reset_busy got %b want %b", busy, CLR); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        oe_n = 1'b1;
    endtask

    task automatic test_clear();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 40) begin cyc(); n++; end
        n_cmp++; if (n != (CLR ? 16 : 0)) begin n_bad++; $display("FAIL clear_busy_cycles got %0d want %0d", n, CLR ? 16 : 0); end
        if (CLR) begin
            oe_n = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                addr = 4'(i);
                cyc();
                n_cmp++; if (bus_out !== 8'h00) begin n_bad++; $display("FAIL clear_word_%0d got %h want 00", i, bus_out); end
            end
            oe_n = 1'b1;
            reset = 1'b1;
            model_reset();
            #1;
            reset = 1'b0;
            for (int i = 0; i < 9; i++) cyc();
            reset = 1'b1;
            model_reset();
            #1;
            reset = 1'b0;
            n = 0;
            while (busy === 1'b1 && n < 40) begin cyc(); n++; end
            n_cmp++; if (n != 16) begin n_bad++; $display("FAIL clear_restart_cycles got %0d want 16", n); end
        end else begin
            for (int i = 0; i < 4; i++) begin
                cyc();
                n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_tied got %b want 0", busy); end
            end
        end
    endtask

    task automatic test_run_rw();
        we = 1'b1; addr = 4'h3; din = 8'hA5; oe_n = 1'b1;
        cyc();
        we = 1'b0;
        n_cmp++; if (bus_out !== 8'h00) begin n_bad++; $display("FAIL rw_oe_off got %h want 00", bus_out); end
        oe_n = 1'b0;
        cyc();
        n_cmp++; if (bus_out !== 8'hA5) begin n_bad++; $display("FAIL rw_read got %h want a5", bus_out); end
        oe_n = 1'b1;
        #1;
        n_cmp++; if (bus_out !== 8'h00) begin n_bad++; $display("FAIL rw_gate got %h want 00", bus_out); end
    endtask

    task automatic test_read_first();
        oe_n = 1'b0; addr = 4'h5; we = 1'b1; din = 8'h11;
        cyc();
        din = 8'h22;
        cyc();
        we = 1'b0;
        n_cmp++; if (bus_out !== 8'h11) begin n_bad++; $display("FAIL read_first_old got %h want 11", bus_out); end
        cyc();
        n_cmp++; if (bus_out !== 8'h22) begin n_bad++; $display("FAIL read_first_new got %h want 22", bus_out); end
    endtask

    task automatic test_load_stream();
        prog_mode = 1'b1; ld_valid = 1'b1; ld_data = 8'h10;
        n_cmp++; if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL load_ready_first got %b want 0", ld_ready); end
        cyc();
        n_cmp++; if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL load_ready_second got %b want 1", ld_ready); end
        for (int i = 0; i < DEPTH; i++) begin
            ld_data = 8'(8'h10 + i);
            cyc();
            n_cmp++; if (ld_addr !== 4'(i + 1)) begin n_bad++; $display("FAIL load_ptr_%0d got %h want %h", i, ld_addr, 4'(i + 1)); end
            n_cmp++; if (ld_wrap !== (i == DEPTH - 1)) begin n_bad++; $display("FAIL load_wrap_%0d got %b want %b", i, ld_wrap, i == DEPTH - 1); end
        end
        prog_mode = 1'b0; ld_valid = 1'b0;
        cyc();
        oe_n = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            addr = 4'(i);
            cyc();
            n_cmp++; if (bus_out !== 8'(8'h10 + i)) begin n_bad++; $display("FAIL load_word_%0d got %h want %h", i, bus_out, 8'(8'h10 + i)); end
        end
    endtask

    task automatic test_restart();
        prog_mode = 1'b1; ld_restart = 1'b1;
        cyc();
        ld_restart = 1'b0; ld_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin ld_data = 8'(8'h40 + i); cyc(); end
        n_cmp++; if (ld_addr !== 4'h7) begin n_bad++; $display("FAIL restart_pre_ptr got %h want 7", ld_addr); end
        ld_data = 8'h5C; ld_restart = 1'b1; we = 1'b1; addr = 4'h2; din = 8'hFF;
        cyc();
        n_cmp++; if (ld_addr !== 4'h0) begin n_bad++; $display("FAIL restart_ptr got %h want 0", ld_addr); end
        n_cmp++; if (ld_wrap !== 1'b0) begin n_bad++; $display("FAIL restart_wrap got %b want 0", ld_wrap); end
        ld_data = 8'h66; ld_restart = 1'b0;
        cyc();
        we = 1'b0; ld_valid = 1'b0; prog_mode = 1'b0;
        cyc();
        addr = 4'h7;
        cyc();
        n_cmp++; if (bus_out !== 8'h5C) begin n_bad++; $display("FAIL restart_word got %h want 5c", bus_out); end
        addr = 4'h2;
        cyc();
        n_cmp++; if (bus_out !== 8'h42) begin n_bad++; $display("FAIL load_we_ignored got %h want 42", bus_out); end
    endtask

    task automatic test_pause_resume();
        prog_mode = 1'b1; ld_restart = 1'b1;
        cyc();
        ld_restart = 1'b0; ld_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin ld_data = 8'(8'h60 + i); cyc(); end
        ld_valid = 1'b0; prog_mode = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_cmp++; if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL pause_ready_%0d got %b want 0", i, ld_ready); end
        end
        prog_mode = 1'b1;
        cyc();
        ld_valid = 1'b1; ld_data = 8'h77;
        cyc();
        n_cmp++; if (ld_addr !== 4'h4) begin n_bad++; $display("FAIL resume_ptr got %h want 4", ld_addr); end
        ld_valid = 1'b0; prog_mode = 1'b0;
        cyc();
        addr = 4'h3;
        cyc();
        n_cmp++; if (bus_out !== 8'h77) begin n_bad++; $display("FAIL resume_word got %h want 77", bus_out); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) prog_mode = ~prog_mode;
            addr = 4'($urandom);
            din = 8'($urandom);
            we = 1'($urandom);
            oe_n = ($urandom_range(0, 3) == 0);
            ld_valid = 1'($urandom);
            ld_data = 8'($urandom);
            ld_restart = ($urandom_range(0, 15) == 0);
            cyc();
            n_cmp++; if (ld_ready !== m_load) begin n_bad++; $display("FAIL rnd_ready_%0d got %b want %b", i, ld_ready, m_load); end
            n_cmp++; if (ld_addr !== m_ptr) begin n_bad++; $display("FAIL rnd_ptr_%0d got %h want %h", i, ld_addr, m_ptr); end
            n_cmp++; if (ld_wrap !== m_wrap) begin n_bad++; $display("FAIL rnd_wrap_%0d got %b want %b", i, ld_wrap, m_wrap); end
            n_cmp++; if (busy !== m_busy) begin n_bad++; $display("FAIL rnd_busy_%0d got %b want %b", i, busy, m_busy); end
            if (oe_n) begin
                n_cmp++; if (bus_out !== 8'h00) begin n_bad++; $display("FAIL rnd_gate_%0d got %h want 00", i, bus_out); end
            end else if (m_rdk) begin
                n_cmp++; if (bus_out !== m_rd) begin n_bad++; $display("FAIL rnd_read_%0d got %h want %h", i, bus_out, m_rd); end
            end
        end
        ld_restart = 1'b0; ld_valid = 1'b0; we = 1'b0; prog_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clear();
        test_run_rw();
        test_read_first();
        test_load_stream();
        test_restart();
        test_pause_resume();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
